i2c_target: RTL and testbench

//  I2C target (slave) endpoint; bus-side counterpart of the I2C_master peripheral.

---
 rtl/i2c_target.sv | 187 ++++++++++++++++++
 tb/tb_i2c_target.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP/address decode,
// byte-stream RX/TX with open-drain SDA and no clock stretching.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  output logic       tx_req_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK
  } state_e;

  // [0],[1] synchronizer, [2] delayed copy for edge detect
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  logic scl_hi;
  logic start_ev;
  logic stop_ev;
  logic rise_ev;
  logic fall_ev;
  logic sda_s;

  assign scl_hi   = scl_q[1] & scl_q[2];
  assign start_ev = scl_hi & sda_q[2] & ~sda_q[1];
  assign stop_ev  = scl_hi & ~sda_q[2] & sda_q[1];
  assign rise_ev  = scl_q[1] & ~scl_q[2];
  assign fall_ev  = ~scl_q[1] & scl_q[2];
  assign sda_s    = sda_q[1];

  state_e     state_q;
  logic [2:0] bitcnt_q;
  logic [7:0] shift_q;
  logic [7:0] shift_d;
  logic       oe_q;
  logic       busy_q;
  logic       rw_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       tx_req_q;
  logic       byte_done;

  assign shift_d   = {shift_q[6:0], sda_s};
  assign byte_done = (bitcnt_q == 3'd7);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'h00;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (stop_ev) begin
        state_q  <= IDLE;
        bitcnt_q <= 3'd0;
        oe_q     <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_ev) begin
        state_q  <= ADDR;
        bitcnt_q <= 3'd0;
        oe_q     <= 1'b0;
      end else if (tx_req_q) begin
        // byte handed over this cycle; MSB goes straight onto the bus
        shift_q <= tx_data_i;
        oe_q    <= ~tx_data_i[7];
      end else begin
        unique case (state_q)
          IDLE: begin
          end
          ADDR: begin
            if (rise_ev) begin
              shift_q  <= shift_d;
              bitcnt_q <= bitcnt_q + 3'd1;
              if (byte_done) begin
                if (shift_q[6:0] == TARGET_ADDR) begin
                  state_q <= ADDR_ACK;
                  busy_q  <= 1'b1;
                  rw_q    <= sda_s;
                end else begin
                  state_q <= IDLE;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (fall_ev) begin
              if (!oe_q) begin
                oe_q <= 1'b1;
              end else if (rw_q) begin
                state_q  <= TX;
                tx_req_q <= 1'b1;
              end else begin
                oe_q    <= 1'b0;
                state_q <= RX;
              end
            end
          end
          RX: begin
            if (rise_ev) begin
              shift_q  <= shift_d;
              bitcnt_q <= bitcnt_q + 3'd1;
              if (byte_done) begin
                rx_data_q  <= shift_d;
                rx_valid_q <= 1'b1;
                state_q    <= RX_ACK;
              end
            end
          end
          RX_ACK: begin
            if (fall_ev) begin
              if (!oe_q) begin
                oe_q <= 1'b1;
              end else begin
                oe_q    <= 1'b0;
                state_q <= RX;
              end
            end
          end
          TX: begin
            if (rise_ev) begin
              shift_q  <= shift_d;
              bitcnt_q <= bitcnt_q + 3'd1;
            end else if (fall_ev) begin
              if (bitcnt_q == 3'd0) begin
                oe_q    <= 1'b0;
                state_q <= TX_ACK;
              end else begin
                oe_q <= ~shift_q[7];
              end
            end
          end
          TX_ACK: begin
            if (rise_ev) begin
              if (sda_s) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else if (fall_ev) begin
              state_q  <= TX;
              tx_req_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sda_oe_o   = oe_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_req_o   = tx_req_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level bus controller plus a transaction
// model of which bytes must be ACKed, received and served.
module tb_i2c_target;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic [7:0] tx_data_i;
  logic       tx_req_o;
  logic       busy_o;

  int nvec = 0;
  int nerr = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int tx_idx = 0;
  logic m_sel = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_bytes[4] = '{8'h5A, 8'hC3, 8'h77, 8'h0F};

  assign sda_bus   = sda_m & ~sda_oe_o;
  assign tx_data_i = tx_bytes[tx_idx % 4];

  always #5 clk = ~clk;

  i2c_target #(.TARGET_ADDR(7'h42)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_oe_o  (sda_oe_o),
    .rx_data_o (rx_data_o),
    .rx_valid_o(rx_valid_o),
    .tx_data_i (tx_data_i),
    .tx_req_o  (tx_req_o),
    .busy_o    (busy_o)
  );

  always @(posedge clk) if (tx_req_o) tx_idx <= tx_idx + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (sda_oe_o) begin
        nvec++;
        if (!m_sel) begin
          nerr++;
          $display("FAIL oe_unselected: sda_oe_o=1 required 0 at %0t", $time);
        end
      end
      if (rx_valid_o) begin
        nvec++;
        rx_cnt++;
        if (exp_rx.size() == 0) begin
          nerr++;
          $display("FAIL rx_unexpected: rx_data_o=%02h required no pulse", rx_data_o);
        end else begin
          automatic logic [7:0] e = exp_rx.pop_front();
          if (rx_data_o !== e) begin
            nerr++;
            $display("FAIL rx_data: got %02h required %02h", rx_data_o, e);
          end
        end
      end
      if (tx_req_o) begin
        nvec++;
        tx_cnt++;
        if (rx_valid_o) begin
          nerr++;
          $display("FAIL req_and_valid: both high required exclusive");
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    wclk(Q);
    sda_m = b;
    wclk(Q);
    scl_m = 1'b1;
    wclk(Q);
    seen = sda_bus;
    wclk(Q);
    scl_m = 1'b0;
  endtask

  task automatic do_start();
    wclk(Q);
    sda_m = 1'b1;
    wclk(Q);
    scl_m = 1'b1;
    wclk(Q);
    sda_m = 1'b0;
    wclk(Q);
    scl_m = 1'b0;
    m_sel = 1'b0;
  endtask

  task automatic do_stop();
    wclk(Q);
    sda_m = 1'b0;
    wclk(Q);
    scl_m = 1'b1;
    wclk(Q);
    sda_m = 1'b1;
    wclk(2 * Q);
    m_sel = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic seen;
    logic ok;
    ok = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(d[i], seen);
      if (seen !== d[i]) ok = 1'b0;
    end
    chk("wr_bits", {31'd0, ok}, 32'd1);
    clock_bit(1'b1, seen);
    ack = ~seen;
  endtask

  task automatic addr(input logic [7:0] d, input logic exp_ack);
    logic ack;
    m_sel = (d[7:1] == 7'h42);
    write_byte(d, ack);
    chk("addr_ack", {31'd0, ack}, {31'd0, exp_ack});
  endtask

  task automatic wr_data(input logic [7:0] d);
    logic ack;
    if (m_sel) exp_rx.push_back(d);
    write_byte(d, ack);
    chk("data_ack", {31'd0, ack}, {31'd0, m_sel});
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic seen;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, seen);
      d[i] = seen;
    end
    clock_bit(~ack, seen);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic seen;
    wclk(3);
    rst = 1'b0;
    wclk(2);
    chk("rst_oe", {31'd0, sda_oe_o}, 32'd0);
    chk("rst_rxv", {31'd0, rx_valid_o}, 32'd0);
    chk("rst_txreq", {31'd0, tx_req_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_rxdata", {24'd0, rx_data_o}, 32'd0);

    do_start();
    addr(8'h84, 1'b1);
    chk("wr_busy", {31'd0, busy_o}, 32'd1);
    wr_data(8'hA5);
    wr_data(8'h3C);
    do_stop();
    chk("wr_busy_end", {31'd0, busy_o}, 32'd0);
    chk("wr_last", {24'd0, rx_data_o}, 32'h3C);
    chk("wr_cnt", rx_cnt, 32'd2);

    do_start();
    addr(8'h85, 1'b1);
    read_byte(1'b1, d);
    chk("rd_b0", {24'd0, d}, 32'h5A);
    read_byte(1'b0, d);
    chk("rd_b1", {24'd0, d}, 32'hC3);
    m_sel = 1'b0;
    do_stop();
    chk("rd_txcnt", tx_cnt, 32'd2);
    chk("rd_busy", {31'd0, busy_o}, 32'd0);

    do_start();
    addr(8'h86, 1'b0);
    chk("mm_busy", {31'd0, busy_o}, 32'd0);
    wr_data(8'hFF);
    do_stop();
    chk("mm_rxcnt", rx_cnt, 32'd2);

    do_start();
    addr(8'h84, 1'b1);
    wr_data(8'h11);
    do_start();
    addr(8'h85, 1'b1);
    read_byte(1'b0, d);
    chk("sr_rd", {24'd0, d}, 32'h77);
    m_sel = 1'b0;
    do_stop();
    chk("sr_rxdata", {24'd0, rx_data_o}, 32'h11);
    chk("sr_txcnt", tx_cnt, 32'd3);
    chk("sr_busy", {31'd0, busy_o}, 32'd0);

    do_start();
    addr(8'h84, 1'b1);
    clock_bit(1'b1, seen);
    clock_bit(1'b0, seen);
    clock_bit(1'b1, seen);
    clock_bit(1'b0, seen);
    do_stop();
    chk("part_rxcnt", rx_cnt, 32'd3);
    chk("part_oe", {31'd0, sda_oe_o}, 32'd0);
    chk("part_busy", {31'd0, busy_o}, 32'd0);
    do_start();
    addr(8'h84, 1'b1);
    wr_data(8'h99);
    do_stop();
    chk("part_next", {24'd0, rx_data_o}, 32'h99);

    do_start();
    addr(8'h85, 1'b1);
    wclk(Q);
    sda_m = 1'b1;
    wclk(Q);
    scl_m = 1'b1;
    wclk(Q);
    chk("tx0_drive", {31'd0, sda_bus}, 32'd0);
    chk("tx0_busy", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    m_sel = 1'b0;
    #1;
    chk("rst_mid_oe", {31'd0, sda_oe_o}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    wclk(2);
    rst = 1'b0;
    wclk(1);
    scl_m = 1'b0;
    do_stop();
    do_start();
    addr(8'h84, 1'b1);
    wr_data(8'h5C);
    do_stop();
    chk("post_rst", {24'd0, rx_data_o}, 32'h5C);
    chk("tot_rx", rx_cnt, 32'd5);
    chk("tot_tx", tx_cnt, 32'd4);
    chk("rx_queue", exp_rx.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
